// File: rtl/mem_access_unit.sv
// MEM-stage access unit: single-outstanding req/ack data port, store lane alignment, load extension.
// Optional REQ timeout abort is compiled in when MEM_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic        loadUnsigned,
  input  logic [31:0] alu,
  input  logic [31:0] storeData,
  input  logic        aluToReg,
  input  logic [4:0]  rd,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        stall,
  output logic [31:0] wbData,
  output logic        wbRegWrite,
  output logic [4:0]  wbRd,
  output logic        misaligned,
  output logic        busError
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  state_t      state, state_next;
  logic [1:0]  size_eff;
  logic        is_load, is_mem, bad_align, start, fault, timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Captured at request so lane selection does not depend on upstream holding alu.
  logic [1:0]  req_lo;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [4:0]  req_rd;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    size_eff   = (memSize == 2'b11) ? SZ_WORD : memSize;
    is_load    = (memOp == OP_LOAD);
    is_mem     = (memOp == OP_LOAD) || (memOp == OP_STORE);
    bad_align  = 1'b0;
    be_next    = 4'b1111;
    wdata_next = storeData;
    case (size_eff)
      SZ_BYTE: begin
        be_next    = 4'b0001 << alu[1:0];
        wdata_next = {4{storeData[7:0]}};
      end
      SZ_HALF: begin
        bad_align  = alu[0];
        be_next    = 4'b0011 << {alu[1], 1'b0};
        wdata_next = {2{storeData[15:0]}};
      end
      default: bad_align = (alu[1:0] != 2'b00);
    endcase
    start = (state == IDLE) && is_mem && !bad_align;
    fault = (state == IDLE) && is_mem && bad_align;

    case (state)
      IDLE: begin
        if (start) begin
          stall      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall = !memAck && !timeout_hit;
        if (memAck || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_lane = memRdata[{req_lo, 3'b000} +: 8];
    half_lane = memRdata[{req_lo[1], 4'b0000} +: 16];
    case (req_size)
      SZ_BYTE: load_ext = {{24{!req_unsigned && byte_lane[7]}}, byte_lane};
      SZ_HALF: load_ext = {{16{!req_unsigned && half_lane[15]}}, half_lane};
      default: load_ext = memRdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= '0;
      memWdata     <= '0;
      memBe        <= '0;
      wbData       <= '0;
      wbRegWrite   <= 1'b0;
      wbRd         <= '0;
      misaligned   <= 1'b0;
      req_lo       <= '0;
      req_size     <= '0;
      req_unsigned <= 1'b0;
      req_rd       <= '0;
    end else begin
      state      <= state_next;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            memReq       <= 1'b1;
            memWe        <= !is_load;
            memAddr      <= {alu[31:2], 2'b00};
            memBe        <= is_load ? 4'b0000 : be_next;
            memWdata     <= is_load ? 32'h0 : wdata_next;
            req_lo       <= alu[1:0];
            req_size     <= size_eff;
            req_unsigned <= loadUnsigned;
            req_rd       <= rd;
            wbRegWrite   <= 1'b0;
          end else if (fault) begin
            misaligned <= 1'b1;
            wbRegWrite <= 1'b0;
            wbRd       <= rd;
            wbData     <= alu;
          end else begin
            wbData     <= alu;
            wbRegWrite <= aluToReg;
            wbRd       <= rd;
          end
        end
        REQ: begin
          if (memAck) begin
            memReq <= 1'b0;
            if (!memWe) begin
              wbData     <= load_ext;
              wbRegWrite <= (req_rd != 5'd0);
              wbRd       <= req_rd;
            end else begin
              wbRegWrite <= 1'b0;
            end
          end else if (timeout_hit) begin
            memReq     <= 1'b0;
            wbRegWrite <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // Fires on the TIMEOUT_CYCLES-th unacknowledged REQ cycle; an ack in that cycle wins.
  assign timeout_hit = (state == REQ) && !memAck &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      busError <= 1'b0;
    end else begin
      busError <= timeout_hit;
      if (start) wait_cnt <= '0;
      else if ((state == REQ) && !memAck) wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign busError    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected requests/writebacks, a monitor pops them.
// Timeout cases run only when MEM_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  memOp = '0;
  logic [1:0]  memSize = '0;
  logic        loadUnsigned = 1'b0;
  logic [31:0] alu = '0;
  logic [31:0] storeData = '0;
  logic        aluToReg = 1'b0;
  logic [4:0]  rd = '0;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memBe;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = '0;
  logic        stall;
  logic [31:0] wbData;
  logic        wbRegWrite;
  logic [4:0]  wbRd;
  logic        misaligned, busError;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .memOp(memOp), .memSize(memSize),
    .loadUnsigned(loadUnsigned), .alu(alu), .storeData(storeData),
    .aluToReg(aluToReg), .rd(rd), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe), .memAck(memAck),
    .memRdata(memRdata), .stall(stall), .wbData(wbData), .wbRegWrite(wbRegWrite),
    .wbRd(wbRd), .misaligned(misaligned), .busError(busError)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic        chk_data;
    logic [31:0] data;
    logic        rw;
    logic [4:0]  rd;
    logic        mis;
    logic        berr;
  } wb_t;

  typedef struct packed {
    logic [7:0]  id;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: an op retires on the edge after a cycle with stall low; its writeback is visible next negedge.
  initial begin
    logic was_free = 1'b0;
    logic req_prev = 1'b0;
    wb_t  w;
    req_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        was_free = 1'b0;
        req_prev = 1'b0;
        continue;
      end
      if (was_free) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", wb_q.size(), 1);
        end else begin
          w = wb_q.pop_front();
          if (w.chk_data) begin
            check($sformatf("wb_data[%0d]", w.id), wbData, w.data);
            check($sformatf("wb_rd[%0d]", w.id), {27'd0, wbRd}, {27'd0, w.rd});
          end
          check($sformatf("wb_regwrite[%0d]", w.id), {31'd0, wbRegWrite}, {31'd0, w.rw});
          check($sformatf("misaligned[%0d]", w.id), {31'd0, misaligned}, {31'd0, w.mis});
          check($sformatf("bus_error[%0d]", w.id), {31'd0, busError}, {31'd0, w.berr});
          check($sformatf("req_dropped[%0d]", w.id), {31'd0, memReq}, 32'd0);
        end
      end
      if (memReq && !req_prev) begin
        if (req_q.size() == 0) begin
          check("req_unexpected", {31'd0, memReq}, 32'd0);
        end else begin
          r = req_q.pop_front();
          check($sformatf("mem_we[%0d]", r.id), {31'd0, memWe}, {31'd0, r.we});
          check($sformatf("mem_addr[%0d]", r.id), memAddr, r.addr);
          if (r.we) begin
            check($sformatf("mem_be[%0d]", r.id), {28'd0, memBe}, {28'd0, r.be});
            check($sformatf("mem_wdata[%0d]", r.id), memWdata, r.wdata);
          end
        end
      end
      req_prev = memReq;
      was_free = !stall;
    end
  end

  // Drives one op starting just after a rising edge; memAck pulses on cycle ack_at (cycle 0 is the IDLE cycle).
  task automatic run_op(
    input int id, input logic [1:0] op, input logic [1:0] size, input logic uns,
    input logic [31:0] a, input logic [31:0] sd, input logic a2r, input logic [4:0] r,
    input logic [31:0] rdata, input int ack_at, input int exp_done,
    input logic exp_req, input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
    input logic e_chk, input logic [31:0] e_data, input logic e_rw, input logic e_mis, input logic e_berr);
    int done_at = -1;
    memOp = op; memSize = size; loadUnsigned = uns; alu = a; storeData = sd;
    aluToReg = a2r; rd = r; memRdata = rdata;
    if (exp_req) req_q.push_back('{id: 8'(id), we: (op == 2'b10), addr: e_addr, be: e_be, wdata: e_wdata});
    wb_q.push_back('{id: 8'(id), chk_data: e_chk, data: e_data, rw: e_rw, rd: r, mis: e_mis, berr: e_berr});
    for (int cyc = 0; cyc < 64; cyc++) begin
      memAck = (cyc == ack_at);
      @(negedge clk);
      if (!stall) begin
        done_at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check($sformatf("stall_cycles[%0d]", id), done_at, exp_done);
    @(posedge clk); #1;
    memAck = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst_mem_req", {31'd0, memReq}, 32'd0);
    check("rst_mem_addr", memAddr, 32'd0);
    check("rst_wb_data", wbData, 32'd0);
    check("rst_wb_regwrite", {31'd0, wbRegWrite}, 32'd0);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check("rst_bus_error", {31'd0, busError}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    //      id op     size   uns  alu           storeData     a2r  rd     rdata         ack done req  addr          be       wdata         chk  data          rw   mis  berr
    run_op(1, 2'b00, 2'b00, 1'b0, 32'h12345678, 32'h0,        1'b1, 5'd5,  32'h0,        0,  0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
    run_op(2, 2'b01, 2'b00, 1'b0, 32'h00001003, 32'h0,        1'b0, 5'd7,  32'h80FF7F01, 3,  3,  1'b1, 32'h00001000, 4'b0000, 32'h0,        1'b1, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
    run_op(3, 2'b10, 2'b01, 1'b0, 32'h00002002, 32'hAABBCCDD, 1'b0, 5'd9,  32'h0,        2,  2,  1'b1, 32'h00002000, 4'b1100, 32'hCCDDCCDD, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    run_op(4, 2'b01, 2'b10, 1'b0, 32'h00003001, 32'h0,        1'b1, 5'd4,  32'h0,        -1, 0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00003001, 1'b0, 1'b1, 1'b0);
    run_op(5, 2'b01, 2'b01, 1'b1, 32'h00004002, 32'h0,        1'b0, 5'd3,  32'h80FF7F01, 1,  1,  1'b1, 32'h00004000, 4'b0000, 32'h0,        1'b1, 32'h000080FF, 1'b1, 1'b0, 1'b0);
    run_op(6, 2'b01, 2'b01, 1'b0, 32'h00004000, 32'h0,        1'b0, 5'd2,  32'h1234F00D, 1,  1,  1'b1, 32'h00004000, 4'b0000, 32'h0,        1'b1, 32'hFFFFF00D, 1'b1, 1'b0, 1'b0);
    run_op(7, 2'b10, 2'b00, 1'b0, 32'h00005001, 32'h000000A5, 1'b0, 5'd1,  32'h0,        1,  1,  1'b1, 32'h00005000, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    run_op(8, 2'b01, 2'b11, 1'b0, 32'h00006000, 32'h0,        1'b1, 5'd0,  32'hDEADBEEF, 2,  2,  1'b1, 32'h00006000, 4'b0000, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    run_op(9, 2'b10, 2'b10, 1'b0, 32'h00007004, 32'h01234567, 1'b0, 5'd8,  32'h0,        1,  1,  1'b1, 32'h00007004, 4'b1111, 32'h01234567, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    run_op(10, 2'b11, 2'b00, 1'b0, 32'hCAFEF00D, 32'h0,       1'b1, 5'd31, 32'h0,        0,  0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    run_op(11, 2'b10, 2'b01, 1'b0, 32'h00008003, 32'h0,       1'b1, 5'd6,  32'h0,        -1, 0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00008003, 1'b0, 1'b1, 1'b0);
    run_op(12, 2'b01, 2'b00, 1'b1, 32'h00009002, 32'h0,       1'b0, 5'd1,  32'h80FF7F01, 1,  1,  1'b1, 32'h00009000, 4'b0000, 32'h0,        1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0);
    run_op(13, 2'b00, 2'b00, 1'b0, 32'h00000000, 32'h0,       1'b0, 5'd10, 32'h0,        -1, 0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);

`ifdef MEM_TIMEOUT_EN
    run_op(20, 2'b01, 2'b10, 1'b0, 32'h0000A000, 32'h0,       1'b0, 5'd11, 32'h0,        -1, 4,  1'b1, 32'h0000A000, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
    run_op(21, 2'b01, 2'b10, 1'b0, 32'h0000A004, 32'h0,       1'b0, 5'd12, 32'h11223344, 4,  4,  1'b1, 32'h0000A004, 4'b0000, 32'h0,        1'b1, 32'h11223344, 1'b1, 1'b0, 1'b0);
`endif

    // Reset while a load sits in REQ with no ack: the request must vanish without a clock edge.
    memOp = 2'b01; memSize = 2'b10; alu = 32'h0000B000; rd = 5'd12; memAck = 1'b0;
    req_q.push_back('{id: 8'd30, we: 1'b0, addr: 32'h0000B000, be: 4'b0000, wdata: 32'h0});
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("req_before_reset", {31'd0, memReq}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_mem_req", {31'd0, memReq}, 32'd0);
    check("rst_mid_mem_we", {31'd0, memWe}, 32'd0);
    check("rst_mid_mem_addr", memAddr, 32'd0);
    check("rst_mid_mem_be", {28'd0, memBe}, 32'd0);
    check("rst_mid_wb_data", wbData, 32'd0);
    check("rst_mid_wb_rd", {27'd0, wbRd}, 32'd0);
    memOp = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    run_op(31, 2'b00, 2'b00, 1'b0, 32'h55AA55AA, 32'h0,       1'b1, 5'd17, 32'h0,        -1, 0,  1'b0, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h55AA55AA, 1'b1, 1'b0, 1'b0);

    @(negedge clk); #1;
    check("wb_queue_drained", wb_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the execute latch outputs: memOp, memSize, ALU result as address, aluToReg and rd.
- Drives a single-outstanding req/ack data-memory port, aligns store lanes and byte enables, and sign/zero-extends load data.
- Stalls the upstream pipeline while a transfer is pending.
- Presents registered writeback fields to the WB stage.

Parameters:
- TIMEOUT_CYCLES, 255: REQ-state cycles without memAck before abort (only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memOp  in  2  00 disable, 01 load, 10 store, 11 reserved (treated as 00).
- memSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- loadUnsigned  in  1  1: zero-extend loads; 0: sign-extend.
- alu  in  32  ALU result: data address for memory ops, writeback value otherwise.
- storeData  in  32  rs2 value for stores.
- aluToReg  in  1  register write enable for non-memory ops.
- rd  in  5  destination register.
- memReq  out  1  request valid; held high until memAck.
- memWe  out  1  1 store, 0 load.
- memAddr  out  32  word-aligned address ({alu[31:2],2'b00}).
- memWdata  out  32  lane-replicated store data.
- memBe  out  4  byte enables.
- memAck  in  1  memory completes the request this cycle; memRdata valid when memWe=0.
- memRdata  in  32  raw word read data.
- stall  out  1  combinational; upstream holds while high.
- wbData  out  32  writeback value.
- wbRegWrite  out  1  writeback enable.
- wbRd  out  5  writeback register.
- misaligned  out  1  one-cycle pulse on an alignment fault.
- busError  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - memReq, memWe, memBe, memAddr, memWdata, wbData, wbRegWrite, wbRd, misaligned, busError all go to 0.
  - Reset during REQ drops memReq immediately; the transfer is abandoned.
- FSM has two states: IDLE and REQ.
- IDLE, memOp is 00 or 11:
  - stall=0.
  - Next edge: wbData<=alu, wbRegWrite<=aluToReg, wbRd<=rd. Latency 1.
- IDLE, memOp is 01 or 10, aligned:
  - stall=1 combinationally.
  - Next edge: register memAddr, memWe, memBe, memWdata; memReq<=1; go to REQ; wbRegWrite<=0.
- Alignment fault: half with alu[0]=1, or word with alu[1:0]!=0.
  - No request is issued; stall=0.
  - Next edge: misaligned<=1 for one cycle, wbRegWrite<=0, wbRd<=rd, wbData<=alu.
- REQ:
  - memReq=1; memAddr, memWe, memBe and memWdata are held stable.
  - stall = !memAck.
  - On the edge where memAck=1: memReq<=0, go to IDLE.
  - Load completion: wbData<=extended lane, wbRegWrite<=(rd!=0), wbRd<=rd.
  - Store completion: wbRegWrite<=0.
  - In the ack cycle stall=0, so upstream advances on the same edge. Back-to-back memory ops therefore cost 2 cycles each minimum.
- Byte enables:
  - byte: 4'b0001<<alu[1:0].
  - half: 4'b0011<<{alu[1],1'b0}.
  - word: 4'b1111.
- Store data:
  - byte: {4{storeData[7:0]}}.
  - half: {2{storeData[15:0]}}.
  - word: storeData.
- Load extraction:
  - byte lane: memRdata[8*alu[1:0]+:8].
  - half lane: memRdata[16*alu[1]+:16].
  - Extension per loadUnsigned; word loads are passed unmodified.
- Inputs are sampled from upstream, which holds them while stall=1. Load lane selection uses the registered alu[1:0] captured at request.
- memAck in IDLE is ignored.
- misaligned and busError are never high in the same cycle.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entry to REQ and increments each REQ cycle without memAck.
  - When the count reaches TIMEOUT_CYCLES with no ack: stall=0 that cycle.
  - Next edge: memReq<=0, busError<=1 for one cycle, wbRegWrite<=0, go to IDLE.
  - memAck in the same cycle as the timeout wins: normal completion, no busError.
- MEM_TIMEOUT_EN undefined:
  - REQ waits indefinitely.
  - busError is tied 0 and no counter is built.

Test Plan:
- ALU passthrough: memOp=00, alu=0x12345678, aluToReg=1, rd=5 -> next cycle wbData=0x12345678, wbRegWrite=1, wbRd=5, stall=0, memReq=0.
- Signed byte load: memOp=01, memSize=00, alu=0x1003, loadUnsigned=0, memRdata=0x80FF7F01, ack after 3 cycles -> memAddr=0x1000, memBe=0000 ignored for load, stall=1 until ack cycle, wbData=0xFFFFFF80, wbRegWrite=1.
- Half store: memOp=10, memSize=01, alu=0x2002, storeData=0xAABBCCDD -> memWe=1, memAddr=0x2000, memBe=1100, memWdata=0xCCDDCCDD, wbRegWrite=0 after ack.
- Misaligned word: memOp=01, memSize=10, alu=0x3001 -> memReq stays 0, misaligned=1 for exactly one cycle, wbRegWrite=0, stall=0.
- Reset mid-transfer: assert reset=0 while in REQ, no ack -> memReq=0 immediately without a clock edge, all outputs 0; after release, a memOp=00 op passes through normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: load with memAck never asserted -> busError=1 for one cycle after 4 REQ cycles, memReq drops, stall releases. Repeat with memAck on the 4th cycle -> normal completion, busError=0.
